// File: rtl/best_idx_reorder_buf_if.sv
// best_idx_reorder_buf_if: stream bundle between the search core, the reorder buffer and the host path.
// Signals: start, in_valid/in_data/in_ready (blocked-order input), out_valid/out_data/out_ready
// (raster-order output), busy, done. master = controlling side, slave = the reorder buffer.
interface best_idx_reorder_buf_if #(parameter int DATA_WIDTH = 11);
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  modport master(output start, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy, done);
  modport slave(input start, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy, done);
endinterface

// File: rtl/best_idx_reorder_buf.sv
// best_idx_reorder_buf: buffers blocked-order best-match indices and replays them in raster order.
// Ports: clk, rst (async, active high), bus (slave modport of best_idx_reorder_buf_if).
// Optional: REORDER_CYCLE_CNT_EN adds output cycle_cnt[31:0], the busy-cycle count of the last frame.
module best_idx_reorder_buf #(
  parameter int DATA_WIDTH = 11,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int NUM_PARTS  = 2,
  parameter int BLOCKING   = 4,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE
) (
  input logic clk,
  input logic rst,
  best_idx_reorder_buf_if.slave bus
`ifdef REORDER_CYCLE_CNT_EN
  , output logic [31:0] cycle_cnt
`endif
);
  localparam int PART_W = ROW_SIZE / NUM_PARTS;
  localparam int NUM_XB = (PART_W + BLOCKING - 1) / BLOCKING;
  localparam int ADDR_W = $clog2(NUM_QUERYS);
  localparam int XI_W   = $clog2(BLOCKING + 1);
  localparam int Y_W    = $clog2(COL_SIZE + 1);
  localparam int XB_W   = $clog2(NUM_XB + 1);
  localparam int PX_W   = $clog2(NUM_PARTS + 1);
  localparam int C_W    = $clog2(PART_W + 1);
  // base-address steps when moving to the next block / next part (may be negative, applied modulo 2^ADDR_W)
  localparam int D_XB   = BLOCKING - (COL_SIZE - 1) * ROW_SIZE;
  localparam int D_PX   = PART_W - (COL_SIZE - 1) * ROW_SIZE - (NUM_XB - 1) * BLOCKING;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_mem [NUM_QUERYS];
  logic [XI_W-1:0]       r_xi;
  logic [Y_W-1:0]        r_y;
  logic [XB_W-1:0]       r_xb;
  logic [PX_W-1:0]       r_px;
  logic [C_W-1:0]        r_cb;
  logic [ADDR_W-1:0]     r_base, r_rp;
  logic                  r_last, r_out_valid, r_done;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  w_start, w_wr, w_xi_end, w_y_end, w_xb_end, w_px_end, w_fill_end, w_ld, w_fin;
  logic [ADDR_W-1:0]     w_addr;

  assign w_start    = r_state == IDLE && bus.start;
  assign w_wr       = r_state == FILL && bus.in_valid;
  // a row inside a block ends at BLOCKING columns or at the part edge (partial last block)
  assign w_xi_end   = r_xi == XI_W'(BLOCKING - 1) || r_cb + C_W'(r_xi) == C_W'(PART_W - 1);
  assign w_y_end    = r_y == Y_W'(COL_SIZE - 1);
  assign w_xb_end   = r_xb == XB_W'(NUM_XB - 1);
  assign w_px_end   = r_px == PX_W'(NUM_PARTS - 1);
  assign w_fill_end = w_xi_end && w_y_end && w_xb_end && w_px_end;
  assign w_addr     = r_base + ADDR_W'(r_xi);
  assign w_ld       = r_state == DRAIN && (!r_out_valid || bus.out_ready) && !r_last;
  assign w_fin      = r_state == DRAIN && r_out_valid && bus.out_ready && r_last;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    w_next = w_start ? FILL : (w_wr && w_fill_end) ? DRAIN : w_fin ? IDLE : r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xi        <= '0;
      r_y         <= '0;
      r_xb        <= '0;
      r_px        <= '0;
      r_cb        <= '0;
      r_base      <= '0;
      r_rp        <= '0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_start) begin
        r_xi   <= '0;
        r_y    <= '0;
        r_xb   <= '0;
        r_px   <= '0;
        r_cb   <= '0;
        r_base <= '0;
        r_rp   <= '0;
        r_last <= 1'b0;
      end else if (w_wr) begin
        if (!w_xi_end) r_xi <= r_xi + 1'b1;
        else begin
          r_xi <= '0;
          if (!w_y_end) begin
            r_y    <= r_y + 1'b1;
            r_base <= r_base + ADDR_W'(ROW_SIZE);
          end else begin
            r_y <= '0;
            if (!w_xb_end) begin
              r_xb   <= r_xb + 1'b1;
              r_cb   <= r_cb + C_W'(BLOCKING);
              r_base <= r_base + ADDR_W'(D_XB);
            end else begin
              r_xb   <= '0;
              r_cb   <= '0;
              r_px   <= w_px_end ? '0 : r_px + 1'b1;
              r_base <= w_px_end ? '0 : r_base + ADDR_W'(D_PX);
            end
          end
        end
      end
      if (w_ld) begin
        r_out_data <= r_mem[r_rp];
        r_last     <= r_rp == ADDR_W'(NUM_QUERYS - 1);
        r_rp       <= r_rp == ADDR_W'(NUM_QUERYS - 1) ? '0 : r_rp + 1'b1;
      end
      r_out_valid <= w_ld || (r_out_valid && !w_fin);
      r_done      <= w_fin;
    end
  end

  always_ff @(posedge clk)
    if (w_wr) r_mem[w_addr] <= bus.in_data;

  assign bus.in_ready  = r_state == FILL;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_state != IDLE;
  assign bus.done      = r_done;

`ifdef REORDER_CYCLE_CNT_EN
  logic [31:0] r_cnt;
  // the accepting start cycle is counted as the first cycle of the frame
  always_ff @(posedge clk or posedge rst)
    if (rst)                  r_cnt <= '0;
    else if (w_start)         r_cnt <= 32'd1;
    else if (r_state != IDLE) r_cnt <= r_cnt + 32'd1;
  assign cycle_cnt = r_cnt;
`endif
endmodule
